// File: rtl/instr_rom_browser.sv
// Steps through instruction ROM words with debounced next/prev buttons and holds the fetched word for the 7-seg driver.
// Optional ADDR_OVERLAY_EN: i_show_addr puts the address on the upper 16 bits of o_disp_data.

module irb_debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);
  localparam int CNT_W = $clog2(CYCLES);

  logic [1:0]       r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // The counter only runs while the synchronised sample disagrees with the accepted level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(CYCLES - 1)) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
        r_press  <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;
endmodule

module instr_rom_browser #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_btn_next,
  input  logic                  i_btn_prev,
  input  logic                  i_show_addr,
  output logic                  o_rom_req,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic                  i_rom_ack,
  input  logic [31:0]           i_rom_data,
  output logic [31:0]           o_disp_data,
  output logic                  o_busy
);
  localparam int NUM_BTN = 2;

  typedef enum logic [1:0] {FETCH_START, WAIT_ACK, IDLE} state_t;

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_press;
  logic               w_next;
  logic               w_prev;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_req;
  logic                  r_busy;
  logic [31:0]           r_data;

  assign w_btn_raw = {i_btn_prev, i_btn_next};

  generate
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      irb_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (w_btn_raw[g]),
        .o_press (w_press[g])
      );
    end
  endgenerate

  // Simultaneous presses cancel each other out.
  assign w_next = w_press[0] & ~w_press[1];
  assign w_prev = w_press[1] & ~w_press[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FETCH_START;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        FETCH_START: begin
          r_req   <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i_rom_ack) begin
            r_data  <= i_rom_data;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (w_next) begin
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_state <= FETCH_START;
          end else if (w_prev) begin
            r_addr  <= r_addr - ADDR_WIDTH'(1);
            r_state <= FETCH_START;
          end
        end
        default: r_state <= FETCH_START;
      endcase
    end
  end

`ifdef ADDR_OVERLAY_EN
  logic [31:0] w_data_nxt;
  logic [31:0] r_disp;

  // Mux off the next data value so an ack still reaches the display in one cycle.
  assign w_data_nxt = (r_state == WAIT_ACK && i_rom_ack) ? i_rom_data : r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_disp <= '0;
    else       r_disp <= i_show_addr ? {16'(r_addr), w_data_nxt[15:0]} : w_data_nxt;
  end

  assign o_disp_data = r_disp;
`else
  logic w_unused_show;
  assign w_unused_show = i_show_addr;
  assign o_disp_data   = r_data;
`endif

  assign o_rom_req  = r_req;
  assign o_rom_addr = r_addr;
  assign o_busy     = r_busy;
endmodule
